// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register access initiator.
package reg_access_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  // rsp_error encoding
  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

endpackage

// File: rtl/reg_access_timer.sv
// Read-wait timer: counts cycles without target ready, saturating at the limit.
module reg_access_timer
  import reg_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hit,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Clear while start is held, otherwise count ready-less cycles up to the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (start)
      count <= '0;
    else if (!hit && count != LIMIT)
      count <= count + CW'(1);
  end

  // A ready in the limit cycle still wins over expiry.
  assign expired = !start && !hit && (count == LIMIT);

endmodule

// File: rtl/reg_access_initiator.sv
// Command/response initiator driving a simple register target with read timeout.
module reg_access_initiator
  import reg_access_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  write_en,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  state_t state, state_nxt;
  logic   alive;
  logic   accept;
  logic   expired;

  assign accept = (state == IDLE) && alive && cmd_valid;

  reg_access_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state != READ_WAIT),
    .hit    (ready),
    .expired(expired)
  );

  // Hold cmd_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode; target strobes come straight from state.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = alive;
        if (accept) state_nxt = cmd_write ? WRITE : READ_WAIT;
      end
      WRITE: begin
        write_en  = 1'b1;
        state_nxt = RESP;
      end
      READ_WAIT: begin
        read_en = 1'b1;
        if (ready || expired) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Target address/data latched at accept; response captured on leaving WRITE/READ_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      data_in   <= '0;
      rsp_rdata <= '0;
      rsp_error <= RSP_OK;
    end else begin
      if (accept) begin
        addr    <= cmd_addr;
        data_in <= cmd_wdata;
      end
      if (state == WRITE) begin
        rsp_rdata <= '0;
        rsp_error <= RSP_OK;
      end else if (state == READ_WAIT) begin
        if (ready) begin
          rsp_rdata <= data_out;
          rsp_error <= RSP_OK;
        end else if (expired) begin
          rsp_rdata <= '0;
          rsp_error <= RSP_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_access_initiator.sv
// Randomized self-checking bench for reg_access_initiator.
module tb_reg_access_initiator;
  import reg_access_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          write_en;
  logic          read_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out = '0;
  logic          ready = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;

  int n_chk = 0;
  int n_err = 0;

  reg_access_initiator #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .write_en(write_en), .read_en(read_en), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_write_en"},  32'(write_en),  32'd0);
    chk({tag, "_read_en"},   32'(read_en),   32'd0);
    chk({tag, "_addr"},      32'(addr),      32'd0);
    chk({tag, "_data_in"},   32'(data_in),   32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
  endtask

  // One transaction. k = cycle after the handshake in which the target raises
  // ready (1 = same cycle read_en first appears). bp = cycles of response
  // backpressure, gap = idle cycles (with random stray ready) before issue.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int k, input logic [DW-1:0] rd, input int bp, input int gap);
    int      exp_lat, exp_re;
    logic [DW-1:0] exp_rd;
    logic    exp_err;
    int      we_n = 0, re_n = 0, both = 0, cv = -1;
    bit      done = 0;

    // Reference outcome from the protocol rules.
    if (wr) begin
      exp_lat = 2; exp_re = 0; exp_rd = '0; exp_err = RSP_OK;
    end else if (k >= 1 && k <= TO + 1) begin
      exp_lat = k + 1; exp_re = k; exp_rd = rd; exp_err = RSP_OK;
    end else begin
      exp_lat = TO + 2; exp_re = TO + 1; exp_rd = '0; exp_err = RSP_TIMEOUT;
    end

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      ready    = 1'($urandom_range(0, 1));
      data_out = DW'($urandom);
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    chk("pre_rsp_valid", 32'(rsp_valid), 32'd0);
    ready     = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;

    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      if (write_en && read_en) both++;
      if (write_en) begin
        we_n++;
        chk("we_addr", 32'(addr), 32'(a));
        chk("we_data", 32'(data_in), 32'(wd));
      end
      if (read_en) begin
        re_n++;
        chk("re_addr", 32'(addr), 32'(a));
      end
      if (rsp_valid) begin
        if (cv < 0) begin
          cv = c;
          chk("rsp_lat", 32'(c), 32'(exp_lat));
        end
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_error", 32'(rsp_error), 32'(exp_err));
        if (c - cv == bp) begin
          rsp_ready = 1'b1;
          done = 1;
        end
      end
      ready    = (!wr && c == k);
      data_out = (!wr && c == k) ? rd : DW'($urandom);
    end
    chk("rsp_seen", 32'(done), 32'd1);
    chk("we_cnt", 32'(we_n), wr ? 32'd1 : 32'd0);
    chk("re_cnt", 32'(re_n), 32'(exp_re));
    chk("we_re_excl", 32'(both), 32'd0);
  endtask

  initial begin
    #1;
    chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed: write, read, timeout (+stale ready), backpressure, ready at limit, one past.
    txn(1'b1, 4'h3, 8'hA5, 0, 8'h00, 0, 0);
    txn(1'b0, 4'h7, 8'h00, 2, 8'hFF, 0, 0);
    txn(1'b0, 4'h2, 8'h00, 99, 8'h5A, 0, 0);
    txn(1'b0, 4'h4, 8'h00, 3, 8'h3C, 0, 2);
    txn(1'b1, 4'h9, 8'h11, 0, 8'h00, 10, 0);
    txn(1'b0, 4'hB, 8'h00, TO + 1, 8'hC3, 0, 0);
    txn(1'b0, 4'hC, 8'h00, TO + 2, 8'h77, 0, 0);
    txn(1'b0, 4'hD, 8'h00, 1, 8'h81, 10, 0);

    // Reset during READ_WAIT.
    @(negedge clk);
    rsp_ready = 1'b0;
    ready     = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_read_en", 32'(read_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_read_en", 32'(read_en), 32'd0);
      ready    = 1'($urandom_range(0, 1));
      data_out = DW'($urandom);
    end
    txn(1'b0, 4'h5, 8'h00, 2, 8'h6E, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(1, TO + 4)),
          DW'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    chk("end_rsp_valid", 32'(rsp_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_access_initiator.md
REG_ACCESS_INITIATOR -- requirements
Module: reg_access_initiator

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8: target data width.
- ADDR_WIDTH, default 4: target address width.
- TIMEOUT_CYCLES, default 15: maximum wait cycles for target ready.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- write_en  out  1  target write strobe.
- read_en  out  1  target read request.
- addr  out  ADDR_WIDTH  target address.
- data_in  out  DATA_WIDTH  target write data.
- data_out  in  DATA_WIDTH  target read data.
- ready  in  1  target read-complete indication.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_error  out  1  1 = read timed out.

Function
REQ-003 FSM states SHALL be IDLE, WRITE, READ_WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On an IDLE handshake, addr/data_in SHALL register cmd_addr/cmd_wdata; the next state SHALL be WRITE if cmd_write=1, else READ_WAIT.
REQ-005 In WRITE, write_en SHALL be 1 for exactly one cycle; writes SHALL be posted, with no ready wait; the next state SHALL be RESP with rsp_error=0 and rsp_rdata=0.
REQ-006 In READ_WAIT, read_en SHALL be held at 1; a wait counter SHALL start at 0 on entry and increment each cycle ready=0.
REQ-007 When ready=1 is sampled in READ_WAIT:
- data_out SHALL be captured into rsp_rdata;
- read_en SHALL deassert the next cycle;
- the state SHALL go to RESP with rsp_error=0.
REQ-008 If the counter reaches TIMEOUT_CYCLES with ready still 0:
- read_en SHALL deassert;
- the state SHALL go to RESP with rsp_error=1 and rsp_rdata=0.
- If ready=1 and the counter reach TIMEOUT_CYCLES in the same cycle, ready SHALL win (no error).
REQ-009 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_error SHALL be stable until rsp_ready=1; the state SHALL then return to IDLE.
REQ-010 Command-to-target latency SHALL be exactly 1 cycle after the handshake.
- Minimum read turnaround, with ready returned one cycle after read_en: rsp_valid 3 cycles after the handshake.
REQ-011 write_en and read_en SHALL never be 1 in the same cycle.
REQ-012 addr and data_in SHALL stay stable from issue until the transaction leaves WRITE/READ_WAIT.
REQ-013 ready=1 sampled outside READ_WAIT SHALL be ignored.
REQ-014 A stale ready from a timed-out read arriving later SHALL NOT affect the next transaction.
REQ-015 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL saturate, never wrapping.
REQ-016 Back-to-back commands SHALL be supported: a new command may be accepted in the cycle after the RESP handshake.

Reset
REQ-017 With rst_n=0, asynchronously:
- state SHALL be IDLE and the counter 0;
- cmd_ready=0 while reset is asserted, rising to 1 in the first cycle after release;
- write_en=0, read_en=0, addr=0, data_in=0;
- rsp_valid=0, rsp_rdata=0, rsp_error=0.
REQ-018 Reset during READ_WAIT or RESP SHALL abort the transaction; no response SHALL be emitted for it after release.

Structure
REQ-019 Package reg_access_pkg SHALL hold:
- the FSM state enum;
- default DATA_WIDTH/ADDR_WIDTH/TIMEOUT_CYCLES constants;
- the rsp_error encoding constants.
REQ-020 The timeout counter SHALL be the sub-module reg_access_timer, with ports clk, rst_n, start, hit, expired.
- start clears the count; hit suppresses expiry.
REQ-021 The block SHALL connect directly to the existing parameterised register target, with matching port names and widths.

Verification
REQ-022 Write:
- Stimulus: cmd write addr=0x3, wdata=0xA5.
- Response: write_en pulses for 1 cycle with addr=0x3, data_in=0xA5; then rsp_valid with rsp_error=0, rsp_rdata=0.
REQ-023 Read:
- Stimulus: read addr=0x7; target returns data_out=0xFF with ready one cycle after read_en.
- Response: rsp_rdata=0xFF, rsp_error=0; read_en high for exactly 2 cycles.
REQ-024 Timeout:
- Stimulus: read with ready tied 0.
- Response: read_en drops after 15 wait cycles; rsp_error=1, rsp_rdata=0; a late ready pulse is ignored.
REQ-025 Backpressure:
- Stimulus: rsp_ready held 0 for 10 cycles.
- Response: rsp_valid and data stay stable; cmd_ready stays 0 until the RESP handshake.
REQ-026 Reset mid-read:
- Stimulus: rst_n low during READ_WAIT.
- Response: all outputs go to reset values immediately; no rsp_valid after release; the next read completes normally.
REQ-027 Ready at limit:
- Stimulus: ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES.
- Response: rsp_error=0 and data captured.
